uart_rx: RTL and testbench

- 8N1 UART receiver: the receive side paired with the team's UART transmitter.
- Synchronises the asynchronous serial input and detects the start bit.
- Samples each bit at mid-period, LSB first, and presents the byte with a one-cycle valid strobe.
- Sits between the pad-level RX pin and the byte-stream consumer (command parser / FIFO).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5,
    BREAK   = 3'd6
  } uart_rx_state_t;

  localparam int DATA_BITS = 8;

  // Width of a cycle counter able to reach clks-1 with one bit of headroom.
  function automatic int clk_cnt_w(input int clks);
    return $clog2(clks) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous input pins. Flops reset to 1 so an
// idle-high line does not look like activity straight after reset.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      meta   <= '1;
      o_sync <= '1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, confirms the start bit at its
// midpoint, samples data bits LSB first at mid-bit and pulses o_rx_dv for a
// correctly framed byte or o_rx_frame_err for a low stop bit.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit and o_rx_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 i_clock,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_active,
  output logic                 o_rx_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_rx_parity_err
`endif
);

  localparam int CNT_W = clk_cnt_w(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state, state_next;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] byte_next;
  logic                 dv_next, frame_err_next, active_next;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit, parity_bit_next;
  logic                 parity_err_next;
`endif

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .i_async (i_rx_serial),
    .o_sync  (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state          <= IDLE;
      clk_cnt        <= CNT_W'(1);
      bit_idx        <= IDX_W'(1);
      shreg          <= '1;
      o_rx_byte      <= '0;
      o_rx_dv        <= 1'b0;
      o_rx_frame_err <= 1'b0;
      o_rx_active    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit      <= 1'b1;
      o_rx_parity_err <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      clk_cnt        <= clk_cnt_next;
      bit_idx        <= bit_idx_next;
      shreg          <= shreg_next;
      o_rx_byte      <= byte_next;
      o_rx_dv        <= dv_next;
      o_rx_frame_err <= frame_err_next;
      o_rx_active    <= active_next;
`ifdef UART_RX_PARITY_EN
      parity_bit      <= parity_bit_next;
      o_rx_parity_err <= parity_err_next;
`endif
    end
  end

  // Frame sequencing: every sample point is a counter match on the synchronised line.
  always_comb begin
    state_next     = state;
    clk_cnt_next   = clk_cnt;
    bit_idx_next   = bit_idx;
    shreg_next     = shreg;
    byte_next      = o_rx_byte;
    dv_next        = 1'b0;
    frame_err_next = 1'b0;
    active_next    = o_rx_active;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit;
    parity_err_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        active_next  = 1'b0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            active_next = 1'b1;
            state_next  = DATA;
          end else begin
            state_next  = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == BIT_CNT) begin
          clk_cnt_next        = '0;
          shreg_next[bit_idx] = rx_s;
          if (bit_idx == LAST_IDX) begin
            bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_CNT) begin
          clk_cnt_next    = '0;
          parity_bit_next = rx_s;
          state_next      = STOP;
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt == BIT_CNT) begin
          clk_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_next = ^{shreg, parity_bit};
`endif
          if (rx_s) begin
            byte_next  = shreg;
            dv_next    = 1'b1;
            state_next = CLEANUP;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_W'(1);
        end
      end
      CLEANUP: begin
        active_next = 1'b0;
        state_next  = IDLE;
      end
      BREAK: begin
        active_next = 1'b0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        clk_cnt_next = '0;
        active_next  = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 8 clocks per bit. A queue of expected
// frame outcomes (timed from each start edge) is compared every cycle against
// dv, frame_err, active and the held byte; literal checks pin key values.
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Start edge -> result slot: 2 sync cycles, half start bit, remaining bit periods, detect and output register.
  localparam int LAT = 2 + HALF + (NBITS - 1) * CPB + 2;
  // Start edge -> first cycle with o_rx_active high.
  localparam int ACT = 2 + HALF + 2;

  typedef struct {
    int         act;
    int         done;
    bit         good;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  logic       i_clock = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx_serial = 1'b1;
  logic       o_rx_dv;
  logic [7:0] o_rx_byte;
  logic       o_rx_active;
  logic       o_rx_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_rx_parity_err;
`endif

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         dv_seen = 0;
  int         err_seen = 0;
  bit         chk_en = 1'b0;
  logic [7:0] model_byte = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock        (i_clock),
    .i_rst          (i_rst),
    .i_rx_serial    (i_rx_serial),
    .o_rx_dv        (o_rx_dv),
    .o_rx_byte      (o_rx_byte),
    .o_rx_active    (o_rx_active),
    .o_rx_frame_err (o_rx_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_rx_parity_err(o_rx_parity_err)
`endif
  );

  always #5 i_clock = ~i_clock;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic pulseReset();
    i_rst = 1'b1;
    @(posedge i_clock);
    #1;
    i_rst = 1'b0;
    q.delete();
    model_byte = 8'h00;
  endtask

  // Drive one frame; bit m lasts len_a cycles when m is even, len_b when odd.
  // abort_bit >= 0 pulses reset partway through that bit and leaves the line idle.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_bit,
                               input int len_a, input int len_b, input int abort_bit);
    logic line [NBITS];
    exp_t e;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = data[i];
`ifdef UART_RX_PARITY_EN
    line[9] = par_bit;
`endif
    line[NBITS-1] = stop_bit;
    e.act  = cyc + ACT;
    e.done = cyc + LAT;
    e.good = stop_bit;
    e.data = data;
    e.perr = ^{data, par_bit};
    q.push_back(e);
    for (int m = 0; m < NBITS; m++) begin
      i_rx_serial = line[m];
      if (m == abort_bit) begin
        waitCycles(3);
        pulseReset();
        i_rx_serial = 1'b1;
        return;
      end
      repeat ((m % 2 == 0) ? len_a : len_b) @(posedge i_clock);
      #1;
    end
  endtask

  // Every-cycle comparison of the DUT against the expected-frame queue.
  always @(negedge i_clock) begin
    logic       exp_dv, exp_err, exp_act, exp_perr;
    logic [7:0] exp_byte;
    if (chk_en) begin
      exp_dv   = 1'b0;
      exp_err  = 1'b0;
      exp_act  = 1'b0;
      exp_perr = 1'b0;
      exp_byte = model_byte;
      if (q.size() > 0) begin
        if (cyc >= q[0].act && cyc <= q[0].done) exp_act = 1'b1;
        if (cyc == q[0].done) begin
          exp_perr = q[0].perr;
          if (q[0].good) begin
            exp_dv   = 1'b1;
            exp_byte = q[0].data;
          end else begin
            exp_err  = 1'b1;
          end
        end
      end
      checkOutput("dv", 32'(o_rx_dv), 32'(exp_dv));
      checkOutput("frame_err", 32'(o_rx_frame_err), 32'(exp_err));
      checkOutput("active", 32'(o_rx_active), 32'(exp_act));
      checkOutput("byte", 32'(o_rx_byte), 32'(exp_byte));
`ifdef UART_RX_PARITY_EN
      checkOutput("parity_err", 32'(o_rx_parity_err), 32'(exp_perr));
`endif
      if (o_rx_dv === 1'b1) dv_seen++;
      if (o_rx_frame_err === 1'b1) err_seen++;
      model_byte = exp_byte;
      if (q.size() > 0 && cyc == q[0].done) q.delete(0);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_rx_serial = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    i_rst  = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_dv", 32'(o_rx_dv), 32'h0);
    checkOutput("reset_err", 32'(o_rx_frame_err), 32'h0);
    checkOutput("reset_active", 32'(o_rx_active), 32'h0);
    checkOutput("reset_byte", 32'(o_rx_byte), 32'h0);
    waitCycles(5);

    $display("[TB] good frames");
    applyStimulus(8'h55, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    checkOutput("byte_55", 32'(o_rx_byte), 32'h55);
    applyStimulus(8'hA3, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    checkOutput("byte_a3", 32'(o_rx_byte), 32'hA3);
    applyStimulus(8'h00, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    applyStimulus(8'hFF, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);

    $display("[TB] glitch");
    i_rx_serial = 1'b0;
    waitCycles(2);
    i_rx_serial = 1'b1;
    waitCycles(20);
    checkOutput("glitch_active", 32'(o_rx_active), 32'h0);
    checkOutput("glitch_byte", 32'(o_rx_byte), 32'hFF);

    $display("[TB] framing error and held-low line");
    applyStimulus(8'h3C, 1'b0, 1'b0, CPB, CPB, -1);
    waitCycles(40);
    i_rx_serial = 1'b1;
    waitCycles(16);
    checkOutput("ferr_byte_held", 32'(o_rx_byte), 32'hFF);
    applyStimulus(8'h81, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    checkOutput("byte_81", 32'(o_rx_byte), 32'h81);

    $display("[TB] back-to-back and bit-length jitter");
    applyStimulus(8'h12, 1'b1, 1'b0, CPB, CPB, -1);
    applyStimulus(8'h34, 1'b1, 1'b1, CPB, CPB, -1);
    applyStimulus(8'h56, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    applyStimulus(8'h9A, 1'b1, 1'b0, CPB - 1, CPB + 1, -1);
    applyStimulus(8'hBC, 1'b1, 1'b1, CPB + 1, CPB - 1, -1);
    applyStimulus(8'hDE, 1'b1, 1'b0, CPB - 1, CPB + 1, -1);
    waitCycles(4);
    checkOutput("byte_de", 32'(o_rx_byte), 32'hDE);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hF0, 1'b1, 1'b0, CPB, CPB, 5);
    checkOutput("abort_dv", 32'(o_rx_dv), 32'h0);
    checkOutput("abort_active", 32'(o_rx_active), 32'h0);
    checkOutput("abort_byte", 32'(o_rx_byte), 32'h0);
    waitCycles(20);
    applyStimulus(8'h0F, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
    checkOutput("byte_0f", 32'(o_rx_byte), 32'h0F);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(8'h07, 1'b1, 1'b1, CPB, CPB, -1);
    waitCycles(4);
    applyStimulus(8'h07, 1'b1, 1'b0, CPB, CPB, -1);
    waitCycles(4);
`endif

    for (int i = 0; i < 400 && q.size() > 0; i++) waitCycles(1);
    checkOutput("queue_drained", 32'(q.size()), 32'h0);
`ifdef UART_RX_PARITY_EN
    checkOutput("dv_count", 32'(dv_seen), 32'd14);
`else
    checkOutput("dv_count", 32'(dv_seen), 32'd12);
`endif
    checkOutput("err_count", 32'(err_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
